if_else_branch_sched: RTL and testbench

- Sequencing controller for the if/else segment datapath.
- Accepts one input word plus the two candidate operands (if-path, else-path) and evaluates the branch condition.
- Issues only the selected operand to a single shared branch compute unit through a start/done handshake, so both sections never run in parallel.
- Returns the combined segment result on a valid/ready output with per-branch statistics and a done-timeout guard.

---
 rtl/if_else_branch_sched.sv | 129 ++++++++++++
 tb/tb_if_else_branch_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/if_else_branch_sched.sv
// Sequencer for the if/else segment: picks one operand per input, runs it through
// the shared branch unit via start/done, and holds the result on a valid/ready port.
module if_else_branch_sched #(
    parameter int              DW        = 32,
    parameter logic [DW-1:0]   COND_MASK = DW'(32'h0000_0001),
    parameter int              TIMEOUT   = 255,
    parameter int              TW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] input_bit,
    input  logic [DW-1:0] array_ref_wire,
    input  logic [DW-1:0] array_ref_m_wire,
    output logic          br_start,
    output logic          br_sel,
    output logic [DW-1:0] br_operand,
    input  logic          br_done,
    input  logic [DW-1:0] br_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] segment_combine,
    output logic          out_branch,
    output logic          out_timeout,
    output logic [15:0]   cnt_if,
    output logic [15:0]   cnt_else,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t        state_reg;
    logic [TW-1:0] timer_reg;
    logic          br_start_reg;
    logic          br_sel_reg;
    logic [DW-1:0] br_operand_reg;
    logic          out_valid_reg;
    logic [DW-1:0] segment_reg;
    logic          out_branch_reg;
    logic          out_timeout_reg;
    logic          cond_in;

    assign cond_in = |(input_bit & COND_MASK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            timer_reg       <= '0;
            br_start_reg    <= 1'b0;
            br_sel_reg      <= 1'b0;
            br_operand_reg  <= '0;
            out_valid_reg   <= 1'b0;
            segment_reg     <= '0;
            out_branch_reg  <= 1'b0;
            out_timeout_reg <= 1'b0;
        end else begin
            br_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // br_sel/br_operand double as the latched condition and operand
                        br_sel_reg     <= cond_in;
                        br_operand_reg <= cond_in ? array_ref_wire : array_ref_m_wire;
                        br_start_reg   <= 1'b1;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_reg <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the expiry cycle still delivers its result
                    if (br_done) begin
                        segment_reg     <= br_result;
                        out_branch_reg  <= br_sel_reg;
                        out_timeout_reg <= 1'b0;
                        out_valid_reg   <= 1'b1;
                        state_reg       <= HOLD;
                    end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                        segment_reg     <= '0;
                        out_branch_reg  <= br_sel_reg;
                        out_timeout_reg <= 1'b1;
                        out_valid_reg   <= 1'b1;
                        state_reg       <= HOLD;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Index 0 counts else-path results, index 1 counts if-path results
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [15:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (state_reg == HOLD && out_ready && !out_timeout_reg &&
                             out_branch_reg == 1'(gi) && cnt_reg != 16'hFFFF) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign cnt_else        = g_cnt[0].cnt_reg;
    assign cnt_if          = g_cnt[1].cnt_reg;
    assign in_ready        = (state_reg == IDLE) && !reset;
    assign busy            = (state_reg != IDLE);
    assign br_start        = br_start_reg;
    assign br_sel          = br_sel_reg;
    assign br_operand      = br_operand_reg;
    assign out_valid       = out_valid_reg;
    assign segment_combine = segment_reg;
    assign out_branch      = out_branch_reg;
    assign out_timeout     = out_timeout_reg;

endmodule

// File: tb/tb_if_else_branch_sched.sv
// Directed bench for if_else_branch_sched: drives transactions cycle by cycle
// against hand-computed expectations with TIMEOUT=4.
module tb_if_else_branch_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input_bit;
    logic [31:0] array_ref_wire;
    logic [31:0] array_ref_m_wire;
    logic        br_start;
    logic        br_sel;
    logic [31:0] br_operand;
    logic        br_done;
    logic [31:0] br_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] segment_combine;
    logic        out_branch;
    logic        out_timeout;
    logic [15:0] cnt_if;
    logic [15:0] cnt_else;
    logic        busy;

    int checks = 0;
    int errors = 0;

    if_else_branch_sched #(
        .DW(32),
        .COND_MASK(32'h0000_0001),
        .TIMEOUT(4),
        .TW(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .input_bit(input_bit),
        .array_ref_wire(array_ref_wire),
        .array_ref_m_wire(array_ref_m_wire),
        .br_start(br_start),
        .br_sel(br_sel),
        .br_operand(br_operand),
        .br_done(br_done),
        .br_result(br_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .segment_combine(segment_combine),
        .out_branch(out_branch),
        .out_timeout(out_timeout),
        .cnt_if(cnt_if),
        .cnt_else(cnt_else),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one input at cycle 0; the unit answers at cycle 1+k when done_en is set.
    task automatic run_txn(input string tag, input logic [31:0] inb, input logic [31:0] a,
                           input logic [31:0] m, input int k, input bit done_en,
                           input logic [31:0] res, input bit exp_sel, input logic [31:0] exp_op,
                           input logic [31:0] exp_res, input bit exp_to, input int hold,
                           input logic [15:0] exp_if, input logic [15:0] exp_else);
        int waitc = 0;
        while (!in_ready && waitc < 20) begin
            step();
            waitc++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid         = 1'b1;
        input_bit        = inb;
        array_ref_wire   = a;
        array_ref_m_wire = m;
        out_ready        = (hold == 0);
        step();
        in_valid = 1'b0;
        check({tag, "_br_start"}, 32'(br_start), 32'd1);
        check({tag, "_br_sel"}, 32'(br_sel), 32'(exp_sel));
        check({tag, "_br_operand"}, br_operand, exp_op);
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        for (int j = 1; j <= k; j++) begin
            step();
            if (j == 1) check({tag, "_br_start_low"}, 32'(br_start), 32'd0);
            if (j == k) begin
                check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
                check({tag, "_operand_stable"}, br_operand, exp_op);
                if (done_en) begin
                    br_done   = 1'b1;
                    br_result = res;
                end
            end
        end
        step();
        br_done   = 1'b0;
        br_result = 32'h5A5A_5A5A;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_segment"}, segment_combine, exp_res);
        check({tag, "_out_branch"}, 32'(out_branch), 32'(exp_sel));
        check({tag, "_out_timeout"}, 32'(out_timeout), 32'(exp_to));
        for (int h = 0; h < hold; h++) begin
            in_valid  = 1'b1;
            input_bit = 32'h0;
            step();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_segment"}, segment_combine, exp_res);
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_no_start"}, 32'(br_start), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check({tag, "_released"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_cnt_if"}, 32'(cnt_if), 32'(exp_if));
        check({tag, "_cnt_else"}, 32'(cnt_else), 32'(exp_else));
        $display("txn %s res=%h branch=%0d timeout=%0d cnt_if=%0d cnt_else=%0d",
                 tag, segment_combine, out_branch, out_timeout, cnt_if, cnt_else);
    endtask

    initial begin
        reset            = 1'b1;
        in_valid         = 1'b0;
        input_bit        = '0;
        array_ref_wire   = '0;
        array_ref_m_wire = '0;
        br_done          = 1'b0;
        br_result        = '0;
        out_ready        = 1'b1;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_br_operand", br_operand, 32'd0);
        reset = 1'b0;
        step();
        check("rst_br_start", 32'(br_start), 32'd0);
        check("rst_cnt_if", 32'(cnt_if), 32'd0);
        check("rst_in_ready_after", 32'(in_ready), 32'd1);
        $display("txn reset in_ready=%0d busy=%0d", in_ready, busy);

        run_txn("if_path", 32'h1, 32'hA5A5_0001, 32'h0000_0055, 1, 1'b1, 32'h1234_5678,
                1'b1, 32'hA5A5_0001, 32'h1234_5678, 1'b0, 0, 16'd1, 16'd0);
        run_txn("else_path", 32'h2, 32'h0000_0077, 32'h0000_00FF, 3, 1'b1, 32'hDEAD_BEEF,
                1'b0, 32'h0000_00FF, 32'hDEAD_BEEF, 1'b0, 0, 16'd1, 16'd1);
        run_txn("timeout", 32'h3, 32'h0BAD_F00D, 32'h0000_0011, 4, 1'b0, 32'h0,
                1'b1, 32'h0BAD_F00D, 32'h0, 1'b1, 0, 16'd1, 16'd1);
        run_txn("done_at_expiry", 32'h0, 32'h0000_0022, 32'h0000_CAFE, 4, 1'b1, 32'h0F0F_0F0F,
                1'b0, 32'h0000_CAFE, 32'h0F0F_0F0F, 1'b0, 0, 16'd1, 16'd2);
        run_txn("backpressure", 32'h1, 32'h1111_2222, 32'h0000_0033, 2, 1'b1, 32'h3333_4444,
                1'b1, 32'h1111_2222, 32'h3333_4444, 1'b0, 10, 16'd2, 16'd2);

        // Reset while waiting on the branch unit, then a stray done
        in_valid         = 1'b1;
        input_bit        = 32'h1;
        array_ref_wire   = 32'h4444_0000;
        array_ref_m_wire = 32'h0;
        step();
        in_valid = 1'b0;
        check("rstwait_br_start", 32'(br_start), 32'd1);
        step();
        check("rstwait_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset     = 1'b0;
        br_done   = 1'b1;
        br_result = 32'h9999_9999;
        check("rstwait_idle", 32'(busy), 32'd0);
        check("rstwait_cnt_if", 32'(cnt_if), 32'd0);
        check("rstwait_cnt_else", 32'(cnt_else), 32'd0);
        check("rstwait_no_start", 32'(br_start), 32'd0);
        step();
        br_done = 1'b0;
        check("rstwait_no_valid", 32'(out_valid), 32'd0);
        check("rstwait_still_idle", 32'(busy), 32'd0);
        step();
        check("rstwait_no_valid2", 32'(out_valid), 32'd0);
        $display("txn reset_in_wait out_valid=%0d busy=%0d", out_valid, busy);

        run_txn("after_reset", 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0044, 1, 1'b1, 32'h600D_600D,
                1'b1, 32'h8000_0001, 32'h600D_600D, 1'b0, 0, 16'd1, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
